// File: rtl/pipe_pkg.sv
// Shared pipeline types for the load scoreboard: register index type,
// architectural register count, outstanding-load limit and the drain FSM
// state encoding.
package pipe_pkg;

   localparam int NREG    = 32;
   localparam int MAX_OUT = 4;

   typedef logic [4:0] regidx_t;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } sb_state_e;

endpackage

// File: rtl/sb_counter.sv
// Up/down counter for loads in flight.
// Counting is bounded in both directions and never wraps:
//  - a decrement at zero is ignored;
//  - an increment at MAX is ignored.
// When inc and dec are both asserted and the decrement is legal, they cancel.
// count_nxt exposes next cycle's value so that the drain FSM can see a
// same-cycle return.
module sb_counter #(
   parameter int MAX = 4,
   parameter int W   = $clog2(MAX + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic [W-1:0] count_nxt,
   output logic         at_max,
   output logic         is_zero
);

   logic dec_ok;

   assign at_max  = (count == W'(MAX));
   assign is_zero = (count == '0);
   assign dec_ok  = dec & ~is_zero;

   // Next count: cancel on inc+dec, otherwise step within bounds.
   always_comb begin
      count_nxt = count;
      if (inc && !dec_ok) begin
         if (!at_max) count_nxt = count + W'(1);
      end else if (dec_ok && !inc) begin
         count_nxt = count - W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) count <= '0;
      else     count <= count_nxt;
   end

endmodule

// File: rtl/load_scoreboard.sv
// Load scoreboard: tracks destination registers of multi-cycle loads and
// stalls l2 while a source (or a WAW destination) is still pending.
// It also enforces an outstanding-load cap and drains all loads on a fence.
//
// Same-cycle returns (ld_done) are bypassed through wval_l3, so they are
// cleared from the hazard view in the cycle they arrive.
//
// Handshake: ld_done is a single-cycle strobe with no back-pressure.
// stall_l2 is combinational in the same cycle as the l2 inputs it depends on.
//
// Optional build macro SCOREBOARD_STATS_EN adds two saturating counters:
//  - stall_cycles;
//  - drain_cycles.
module load_scoreboard
   import pipe_pkg::*;
#(
   parameter int NREG    = pipe_pkg::NREG,
   parameter int MAX_OUT = pipe_pkg::MAX_OUT,
   parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_l2,
   input  logic [4:0]       rs1_l2,
   input  logic [4:0]       rs2_l2,
   input  logic             use_rs1_l2,
   input  logic             use_rs2_l2,
   input  logic [4:0]       rd_l2,
   input  logic             is_load_l2,
   input  logic             is_fence_l2,
   input  logic             flush_l2,
   input  logic             ld_done,
   input  logic [4:0]       ld_rd,
   output logic             stall_l2,
   output logic [CNT_W-1:0] pend_cnt,
`ifdef SCOREBOARD_STATS_EN
   output logic [31:0]      stall_cycles,
   output logic [31:0]      drain_cycles,
`endif
   output logic             busy
);

   logic [NREG-1:0]  pending;
   logic [NREG-1:0]  pending_nxt;
   logic [NREG-1:0]  eff;
   logic [CNT_W-1:0] cnt_nxt;
   sb_state_e        state;
   logic             at_max;
   logic             is_zero;
   logic             live;
   logic             haz_src;
   logic             haz_cap;
   logic             haz_waw;
   logic             fence_go;
   logic             fsm_stall;
   logic             issue;

   assign live = valid_l2 & ~flush_l2;
   assign busy = ~is_zero;

   // Hazard view: a load returning this cycle is already forwarded.
   always_comb begin
      eff = pending;
      if (ld_done) eff[ld_rd] = 1'b0;
   end

   assign haz_src   = (use_rs1_l2 & eff[rs1_l2]) | (use_rs2_l2 & eff[rs2_l2]);
   assign haz_cap   = is_load_l2 & at_max & ~ld_done;
   assign haz_waw   = is_load_l2 & eff[rd_l2] & (rd_l2 != 5'd0);
   assign fence_go  = live & is_fence_l2 & busy & (state == RUN);
   assign fsm_stall = (state == DRAIN) | fence_go;
   assign stall_l2  = live & (haz_src | haz_cap | haz_waw | fsm_stall);

   // Loads to x0 still occupy a memory slot, so they count but set no bit.
   assign issue = live & ~stall_l2 & is_load_l2;

   sb_counter #(
      .MAX (MAX_OUT),
      .W   (CNT_W)
   ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (issue),
      .dec       (ld_done),
      .count     (pend_cnt),
      .count_nxt (cnt_nxt),
      .at_max    (at_max),
      .is_zero   (is_zero)
   );

   // Next bitmap: clear the returning rd first, then set the issuing rd.
   always_comb begin
      pending_nxt = pending;
      if (ld_done) pending_nxt[ld_rd] = 1'b0;
      if (issue && rd_l2 != 5'd0) pending_nxt[rd_l2] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   // Pending bitmap register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pending <= '0;
      else     pending <= pending_nxt;
   end

   // Drain FSM: hold l2 from a busy fence until every load has returned.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
      end else begin
         case (state)
            RUN:     if (fence_go) state <= DRAIN;
            DRAIN:   if (flush_l2 || cnt_nxt == '0) state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

   // A return with nothing outstanding means the memory side lost track.
   a_no_spurious_return: assert property (
      @(posedge clk) disable iff (rst) !(ld_done && is_zero)
   );

`ifdef SCOREBOARD_STATS_EN
   // Saturating activity counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
         drain_cycles <= '0;
      end else begin
         if (stall_l2 && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
         if (state == DRAIN && drain_cycles != '1) drain_cycles <= drain_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_load_scoreboard.sv
// Directed bench for load_scoreboard with hand-computed expectations.
module tb_load_scoreboard;
  import pipe_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_l2, use_rs1_l2, use_rs2_l2, is_load_l2, is_fence_l2, flush_l2, ld_done;
  logic [4:0] rs1_l2, rs2_l2, rd_l2, ld_rd;
  logic       stall_l2, busy;
  logic [2:0] pend_cnt;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles, drain_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  load_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .valid_l2    (valid_l2),
    .rs1_l2      (rs1_l2),
    .rs2_l2      (rs2_l2),
    .use_rs1_l2  (use_rs1_l2),
    .use_rs2_l2  (use_rs2_l2),
    .rd_l2       (rd_l2),
    .is_load_l2  (is_load_l2),
    .is_fence_l2 (is_fence_l2),
    .flush_l2    (flush_l2),
    .ld_done     (ld_done),
    .ld_rd       (ld_rd),
    .stall_l2    (stall_l2),
    .pend_cnt    (pend_cnt),
`ifdef SCOREBOARD_STATS_EN
    .stall_cycles(stall_cycles),
    .drain_cycles(drain_cycles),
`endif
    .busy        (busy)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    valid_l2 = 0; use_rs1_l2 = 0; use_rs2_l2 = 0; is_load_l2 = 0;
    is_fence_l2 = 0; flush_l2 = 0; ld_done = 0;
    rs1_l2 = 0; rs2_l2 = 0; rd_l2 = 0; ld_rd = 0;
  endtask

  // advance one cycle; inputs change 1 time unit after the edge
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // settle combinational outputs before sampling
  task automatic settle();
    #2;
  endtask

  task automatic drv_load(input logic [4:0] rd);
    idle(); valid_l2 = 1; is_load_l2 = 1; rd_l2 = rd;
  endtask

  task automatic drv_use(input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2);
    idle(); valid_l2 = 1; rs1_l2 = r1; rs2_l2 = r2; use_rs1_l2 = u1; use_rs2_l2 = u2;
  endtask

  task automatic ret(input logic [4:0] rd);
    ld_done = 1; ld_rd = rd;
  endtask

  initial begin
    idle();
    rst = 1;
    #12;
    check("reset_stall", {31'b0, stall_l2}, 0);
    check("reset_cnt", {29'b0, pend_cnt}, 0);
    check("reset_busy", {31'b0, busy}, 0);
    check("reset_pending", dut.pending, 0);
    @(negedge clk); rst = 0;
    nxt();

    // RAW on x5
    drv_load(5); settle();
    check("t1_issue_stall", {31'b0, stall_l2}, 0);
    nxt();
    check("t1_cnt", {29'b0, pend_cnt}, 1);
    check("t1_busy", {31'b0, busy}, 1);
    drv_use(5, 0, 1, 0); settle();
    check("t1_raw_stall_a", {31'b0, stall_l2}, 1);
    nxt(); settle();
    check("t1_raw_stall_b", {31'b0, stall_l2}, 1);
    nxt();
    ret(5); settle();
    check("t1_bypass_stall", {31'b0, stall_l2}, 0);
    nxt(); idle();
    check("t1_pending_clr", dut.pending, 0);
    check("t1_cnt_zero", {29'b0, pend_cnt}, 0);

    // load to x0
    drv_load(0); settle();
    check("t2_issue_stall", {31'b0, stall_l2}, 0);
    nxt();
    check("t2_cnt", {29'b0, pend_cnt}, 1);
    check("t2_no_bit", dut.pending, 0);
    drv_use(0, 0, 1, 1); settle();
    check("t2_x0_stall", {31'b0, stall_l2}, 0);
    nxt(); idle();
    check("t2_cnt_hold", {29'b0, pend_cnt}, 1);
    ret(0); nxt(); idle();
    check("t2_cnt_ret", {29'b0, pend_cnt}, 0);

    // outstanding cap
    for (int r = 1; r <= 4; r++) begin
      drv_load(5'(r)); settle();
      check("t3_fill_stall", {31'b0, stall_l2}, 0);
      nxt();
    end
    check("t3_cnt_full", {29'b0, pend_cnt}, 4);
    drv_load(6); settle();
    check("t3_cap_stall", {31'b0, stall_l2}, 1);
    nxt();
    drv_load(6); ret(2); settle();
    check("t3_cap_release", {31'b0, stall_l2}, 0);
    nxt(); idle();
    check("t3_cnt_same", {29'b0, pend_cnt}, 4);
    check("t3_pending", dut.pending, 32'h0000_005A);
    ret(1); nxt(); ret(3); nxt(); ret(4); nxt(); ret(6); nxt(); idle();
    check("t3_cnt_drained", {29'b0, pend_cnt}, 0);

    // fence drain
    drv_load(7); nxt();
    drv_load(8); nxt();
    idle(); valid_l2 = 1; is_fence_l2 = 1; settle();
    check("t4_fence_stall", {31'b0, stall_l2}, 1);
    nxt(); settle();
    check("t4_state_drain", 32'(dut.state), 32'(DRAIN));
    check("t4_drain_stall_a", {31'b0, stall_l2}, 1);
    nxt();
    ret(7); settle();
    check("t4_drain_stall_b", {31'b0, stall_l2}, 1);
    nxt();
    ld_rd = 8; settle();
    check("t4_drain_stall_c", {31'b0, stall_l2}, 1);
    nxt(); ld_done = 0; settle();
    check("t4_state_run", 32'(dut.state), 32'(RUN));
    check("t4_fence_pass", {31'b0, stall_l2}, 0);
    check("t4_cnt", {29'b0, pend_cnt}, 0);
    nxt(); idle();

    // flush priority, then reset mid-drain
    drv_load(9); nxt();
    drv_use(0, 9, 0, 1); flush_l2 = 1; settle();
    check("t5_flush_stall", {31'b0, stall_l2}, 0);
    nxt(); idle();
    check("t5_pending9", {31'b0, dut.pending[9]}, 1);
    check("t5_cnt", {29'b0, pend_cnt}, 1);
    valid_l2 = 1; is_fence_l2 = 1; nxt(); settle();
    check("t5_in_drain", 32'(dut.state), 32'(DRAIN));
    check("t5_drain_stall", {31'b0, stall_l2}, 1);
    rst = 1; #1;
    check("t5_rst_cnt", {29'b0, pend_cnt}, 0);
    check("t5_rst_busy", {31'b0, busy}, 0);
    check("t5_rst_stall", {31'b0, stall_l2}, 0);
    check("t5_rst_state", 32'(dut.state), 32'(RUN));
    check("t5_rst_pending", dut.pending, 0);
    idle();
    @(negedge clk); rst = 0;
    nxt();

    // WAW on x3
    drv_load(3); nxt();
    drv_load(3); settle();
    check("t6_waw_stall_a", {31'b0, stall_l2}, 1);
    nxt(); settle();
    check("t6_waw_stall_b", {31'b0, stall_l2}, 1);
    nxt();
    ret(3); settle();
    check("t6_waw_release", {31'b0, stall_l2}, 0);
    nxt(); idle();
    check("t6_pending3", dut.pending, 32'h0000_0008);
    check("t6_cnt", {29'b0, pend_cnt}, 1);
    ret(3); nxt(); idle();
    check("t6_final_cnt", {29'b0, pend_cnt}, 0);
    nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // watchdog
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
